tt_um_seven_segment_reader: RTL

TT_UM_SEVEN_SEGMENT_READER -- requirements
Module: tt_um_seven_segment_reader

---
 rtl/tt_um_seven_segment_reader.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/tt_um_seven_segment_reader.sv
// Seven-segment pattern reader: debounces a segment bus and decodes it to a digit,
// with validity, sticky error, change pulse, blank flag and an accepted-change counter.
module tt_um_seven_segment_reader #(
  parameter int unsigned STABLE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {IDLE, SETTLE, LOCKED} state_t;
  typedef enum logic [1:0] {KIND_DIGIT, KIND_BLANK, KIND_BAD} kind_t;

  localparam logic [15:0] CNT_LAST = 16'(STABLE_CYCLES - 1);

  state_t      state, state_nxt;
  logic [7:0]  sync1, sync2;
  logic [1:0]  prime;
  logic [6:0]  pattern;
  logic [6:0]  cand, cand_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic        accept;
  logic [3:0]  dec_val;
  kind_t       dec_kind;

  logic [3:0]  digit;
  logic        valid, error, chg, blank;
  logic [7:0]  count;

  logic unused_inputs;
  assign unused_inputs = &{1'b0, ena, uio_in};

  // prime marks when sync2 holds a real sample, so IDLE never settles on reset zeros
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      prime <= '0;
    end else begin
      sync1 <= ui_in;
      sync2 <= sync1;
      prime <= {prime[0], 1'b1};
    end
  end

  assign pattern = sync2[7] ? ~sync2[6:0] : sync2[6:0];

  always_comb begin
    dec_val  = 4'd0;
    dec_kind = KIND_DIGIT;
    case (pattern)
      7'b0111111: dec_val = 4'd0;
      7'b0000110: dec_val = 4'd1;
      7'b1011011: dec_val = 4'd2;
      7'b1001111: dec_val = 4'd3;
      7'b1100110: dec_val = 4'd4;
      7'b1101101: dec_val = 4'd5;
      7'b1111100: dec_val = 4'd6;
      7'b0000111: dec_val = 4'd7;
      7'b1111111: dec_val = 4'd8;
      7'b1100111: dec_val = 4'd9;
      7'b0000000: dec_kind = KIND_BLANK;
      default:    dec_kind = KIND_BAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cand  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cand  <= cand_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cand_nxt  = cand;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    if (state == IDLE) begin
      if (prime[1]) begin
        cand_nxt  = pattern;
        cnt_nxt   = '0;
        state_nxt = SETTLE;
      end
    end else if (pattern != cand) begin
      cand_nxt  = pattern;
      cnt_nxt   = '0;
      state_nxt = SETTLE;
    end else if (state == SETTLE) begin
      // the loading sample is not counted; the STABLE_CYCLES-th match accepts
      if (cnt == CNT_LAST) begin
        accept    = 1'b1;
        cnt_nxt   = '0;
        state_nxt = LOCKED;
      end else begin
        cnt_nxt = cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit <= '0;
      valid <= 1'b0;
      error <= 1'b0;
      chg   <= 1'b0;
      blank <= 1'b0;
      count <= '0;
    end else begin
      chg <= 1'b0;
      if (accept) begin
        case (dec_kind)
          KIND_DIGIT: begin
            digit <= dec_val;
            valid <= 1'b1;
            blank <= 1'b0;
            if (!valid || digit != dec_val) begin
              chg   <= 1'b1;
              count <= count + 8'd1;
            end
          end
          KIND_BLANK: begin
            valid <= 1'b0;
            blank <= 1'b1;
          end
          default: begin
            error <= 1'b1;
            valid <= 1'b0;
            blank <= 1'b0;
          end
        endcase
      end
    end
  end

  assign uo_out  = {blank, chg, error, valid, digit};
  assign uio_out = count;
  assign uio_oe  = 8'hFF;

endmodule
